spi_sequencer: RTL

- Sequences multi-byte SPI transfers through the byte-level SPI master (mode 0, 8-bit, MSB first).
- Holds an internal byte buffer that the host loads with tx bytes. The sequencer then performs xfer_len back-to-back byte transfers under one chip-select assertion.
- Each received byte overwrites the tx byte it was exchanged with.
- Sits between the memory-mapped SPI controller and the byte master.

---
 rtl/spi_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/spi_sequencer.sv
// Multi-byte SPI transfer sequencer: streams buffer bytes through the byte-level
// master under one chip-select and overwrites each byte with the byte received for it.
module spi_sequencer #(
    parameter int BUF_DEPTH = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   xfer_len,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic              buf_wr_en,
    input  logic [7:0]        buf_wdata,
    output logic [7:0]        buf_rdata,
    output logic              cs_n,
    output logic              xfer_start,
    output logic [7:0]        tx_data,
    input  logic              xfer_complete,
    input  logic [7:0]        rx_data
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   len_q;
    logic              busy_q;
    logic              done_q;
    logic              cs_n_q;
    logic              xs_q;
    logic [7:0]        tx_q;
    logic [7:0]        rdata_q;
    logic [7:0]        mem_q [BUF_DEPTH];

    logic              last_byte;
    logic              seq_wr;
    logic              host_wr;

    // Widen idx so that len == BUF_DEPTH terminates at BUF_DEPTH-1 without wrapping.
    assign last_byte = ({1'b0, idx_q} == (len_q - ONE));
    assign seq_wr    = (state_q == S_WAIT) && xfer_complete;
    assign host_wr   = (state_q == S_IDLE) && buf_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            xs_q    <= 1'b0;
            tx_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (xfer_len != '0)) begin
                        len_q   <= (xfer_len > DEPTH) ? DEPTH : xfer_len;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cs_n_q  <= 1'b0;
                    tx_q    <= mem_q[idx_q];
                    xs_q    <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    xs_q    <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (xfer_complete) begin
                        if (last_byte) begin
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Buffer contents survive reset; the two writers are exclusive by state.
    always_ff @(posedge clk) begin
        if (seq_wr) begin
            mem_q[idx_q] <= rx_data;
        end else if (host_wr) begin
            mem_q[buf_addr] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[buf_addr];
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cs_n       = cs_n_q;
    assign xfer_start = xs_q;
    assign tx_data    = tx_q;
    assign buf_rdata  = rdata_q;

endmodule
